// File: rtl/pcw_video_pkg.sv
// rtl/pcw_video_pkg.sv - shared types and helpers for the PCW palette loader
// Contents: pal_state_t (loader FSM states), PAL_IDX_DEFAULT (default ioctl
// index), PAL_MAX_BITS (widest supported palette vector), and pal_entry()
// (extracts one entry from a packed palette vector).
package pcw_video_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_SWAP = 2'd2
  } pal_state_t;

  localparam logic [7:0] PAL_IDX_DEFAULT = 8'd3;

  // 256 entries of 3 x 8-bit channels is the largest palette we build.
  localparam int PAL_MAX_BITS = 256 * 24;

  // Returns entry i of a packed palette whose entries are ew bits wide.
  // The result is right-aligned in 24 bits; callers truncate to their width.
  function automatic logic [23:0] pal_entry(input logic [PAL_MAX_BITS-1:0] vec,
                                            input int i, input int ew);
    logic [23:0] mask;
    mask = (24'd1 << ew) - 24'd1;
    return 24'(vec >> (i * ew)) & mask;
  endfunction

endpackage

// File: rtl/pcw_palette_loader_if.sv
// rtl/pcw_palette_loader_if.sv - data_io ioctl download bundle
// Signals: ioctl_download (download active), ioctl_index (target index),
// ioctl_wr (single-cycle byte strobe), ioctl_data (download byte).
// Modports: master drives the stream (data_io / bench), slave receives it.
interface pcw_palette_loader_if;
  logic       ioctl_download;
  logic [7:0] ioctl_index;
  logic       ioctl_wr;
  logic [7:0] ioctl_data;

  modport master (output ioctl_download, ioctl_index, ioctl_wr, ioctl_data);
  modport slave  (input  ioctl_download, ioctl_index, ioctl_wr, ioctl_data);
endinterface

// File: rtl/pcw_palette_bank.sv
// rtl/pcw_palette_bank.sv - two-bank palette register file
// Ports: clk, rst_n (async active-low, reloads DEFAULT_PAL into both banks);
// write port wr_en/wr_bank/wr_addr/wr_data; registered read port
// rd_bank/rd_addr -> rd_data (1-cycle latency, cleared on reset).
module pcw_palette_bank
  import pcw_video_pkg::*;
#(
  parameter int                        ENTRIES     = 16,
  parameter int                        CW          = 8,
  parameter logic [ENTRIES*3*CW-1:0]   DEFAULT_PAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       wr_bank,
  input  logic [$clog2(ENTRIES)-1:0] wr_addr,
  input  logic [3*CW-1:0]            wr_data,
  input  logic                       rd_bank,
  input  logic [$clog2(ENTRIES)-1:0] rd_addr,
  output logic [3*CW-1:0]            rd_data
);

  localparam int EW = 3 * CW;

  logic [EW-1:0] mem     [2][ENTRIES];
  logic [EW-1:0] def_ent [ENTRIES];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_def
    assign def_ent[gi] = EW'(pal_entry(PAL_MAX_BITS'(DEFAULT_PAL), gi, EW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          mem[b][e] <= def_ent[e];
        end
      end
    end else if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_bank][rd_addr];
    end
  end

endmodule

// File: rtl/pcw_palette_loader.sv
// rtl/pcw_palette_loader.sv - double-buffered palette loaded from data_io
// Ports: clk_sys, reset_n (async active-low); ioctl (slave download bundle);
// swap_en (high when a bank flip is safe); rd_idx -> rd_rgb ({R,G,B} of the
// active bank, 1-cycle latency); busy (LOAD or WAIT_SWAP); loaded (sticky
// after first commit); load_err (one-cycle pulse on a discarded load).
module pcw_palette_loader
  import pcw_video_pkg::*;
#(
  parameter int                      ENTRIES     = 16,
  parameter int                      CW          = 8,
  parameter logic [7:0]              IOCTL_IDX   = PAL_IDX_DEFAULT,
  parameter logic [ENTRIES*3*CW-1:0] DEFAULT_PAL = '0
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  pcw_palette_loader_if.slave        ioctl,
  input  logic                       swap_en,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output logic [3*CW-1:0]            rd_rgb,
  output logic                       busy,
  output logic                       loaded,
  output logic                       load_err
);

  localparam int             AW        = $clog2(ENTRIES);
  localparam logic [AW:0]    ENTRIES_W = (AW+1)'(ENTRIES);

  pal_state_t    state, state_n;
  logic          active;
  logic          sel, sel_q, sel_rise, sel_fall;
  logic [1:0]    chan, chan_n;
  logic [AW:0]   entry, entry_n;
  logic          ovf, ovf_n;
  logic [CW-1:0] r_hold, r_n, g_hold, g_n;
  logic [CW-1:0] byte_ch;
  logic          wr_en, flip, set_loaded, err_n;

  assign sel      = ioctl.ioctl_download && (ioctl.ioctl_index == IOCTL_IDX);
  assign sel_rise = sel && !sel_q;
  assign sel_fall = !sel && sel_q;
  assign byte_ch  = ioctl.ioctl_data[7 -: CW];
  assign busy     = (state != IDLE);

  always_comb begin
    state_n    = state;
    chan_n     = chan;
    entry_n    = entry;
    ovf_n      = ovf;
    r_n        = r_hold;
    g_n        = g_hold;
    wr_en      = 1'b0;
    flip       = 1'b0;
    set_loaded = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (sel_rise) begin
          state_n = LOAD;
          chan_n  = 2'd0;
          entry_n = '0;
          ovf_n   = 1'b0;
        end
      end
      LOAD: begin
        // A strobe coinciding with the falling edge of sel still belongs to
        // this load, so it is accepted while sel_q is high.
        if (ioctl.ioctl_wr && (sel || sel_fall)) begin
          if (entry == ENTRIES_W) begin
            ovf_n = 1'b1;
          end else begin
            case (chan)
              2'd0: begin
                r_n    = byte_ch;
                chan_n = 2'd1;
              end
              2'd1: begin
                g_n    = byte_ch;
                chan_n = 2'd2;
              end
              default: begin
                wr_en   = 1'b1;
                entry_n = entry + 1'b1;
                chan_n  = 2'd0;
              end
            endcase
          end
        end
        // End decision uses the counters after this cycle's byte.
        if (sel_fall) begin
          if (entry_n == ENTRIES_W && chan_n == 2'd0 && !ovf_n) begin
            state_n = WAIT_SWAP;
          end else begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        if (swap_en) begin
          flip       = 1'b1;
          set_loaded = 1'b1;
          state_n    = IDLE;
        end
        // A new download restarts the shadow fill; if the swap fires in the
        // same cycle the completed load is still committed first.
        if (sel_rise) begin
          state_n = LOAD;
          chan_n  = 2'd0;
          entry_n = '0;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      active   <= 1'b0;
      sel_q    <= 1'b0;
      chan     <= 2'd0;
      entry    <= '0;
      ovf      <= 1'b0;
      r_hold   <= '0;
      g_hold   <= '0;
      loaded   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      active   <= active ^ flip;
      sel_q    <= sel;
      chan     <= chan_n;
      entry    <= entry_n;
      ovf      <= ovf_n;
      r_hold   <= r_n;
      g_hold   <= g_n;
      loaded   <= loaded | set_loaded;
      load_err <= err_n;
    end
  end

  pcw_palette_bank #(
    .ENTRIES     (ENTRIES),
    .CW          (CW),
    .DEFAULT_PAL (DEFAULT_PAL)
  ) u_bank (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .wr_en   (wr_en),
    .wr_bank (~active),
    .wr_addr (entry[AW-1:0]),
    .wr_data ({r_hold, g_hold, byte_ch}),
    .rd_bank (active),
    .rd_addr (rd_idx),
    .rd_data (rd_rgb)
  );

endmodule

// File: doc/pcw_palette_loader.md
Name: pcw_palette_loader

Overview:
- Parametrised successor to the fixed 128-bit palette shift register in the guest top level.
- Holds an ENTRIES-deep RGB palette in two banks, each entry 3*CW bits. Bank load is from the data_io ioctl byte stream, filtered by ioctl index.
- Commits a completed load atomically: the bank flip happens only when swap_en is high (display blanking). The video path never sees a half-written palette.
- Gives pcw_core a registered lookup port for fake-colour modes.

Parameters:
- ENTRIES, 16: number of palette entries (power of two, 2..256).
- CW, 8: bits per colour channel (1..8); each received byte supplies one channel, taken from its top CW bits.
- IOCTL_IDX, 8'd3: ioctl_index value that selects this loader.
- DEFAULT_PAL, all zero, ENTRIES*3*CW bits: reset contents of both banks. Entry i is at [(i+1)*3*CW-1 : i*3*CW], ordered {R,G,B}.

Ports:
- clk_sys  in  1  system clock (64 MHz).
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  data_io download active.
- ioctl_index  in  8  data_io download target index.
- ioctl_wr  in  1  single-cycle byte strobe.
- ioctl_data  in  8  download byte.
- swap_en  in  1  level; high = safe to flip banks (vblank).
- rd_idx  in  $clog2(ENTRIES)  lookup index.
- rd_rgb  out  3*CW  {R,G,B} of active-bank entry rd_idx.
- busy  out  1  high in LOAD or WAIT_SWAP.
- loaded  out  1  sticky; set by the first successful commit.
- load_err  out  1  one-cycle pulse on a discarded load.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; active bank=0; both banks=DEFAULT_PAL.
  - Byte and entry counters=0; rd_rgb=0; busy=0; loaded=0; load_err=0.
  - Any load or pending swap in progress is abandoned.
- sel = ioctl_download && ioctl_index==IDX. sel_rise and sel_fall are edges of a registered copy of sel.
- IDLE:
  - On sel_rise → LOAD; clear counters (chan 0..2, entry 0..ENTRIES-1, overflow flag).
- LOAD:
  - Each ioctl_wr with sel high stores ioctl_data[7:8-CW] into a channel holding register. Order is R, G, B.
  - On the B byte, the assembled entry is written to the shadow bank (~active) at the entry counter; entry++ and chan→0.
  - Bytes after ENTRIES*3 are dropped and set overflow.
  - ioctl_wr while sel is low is ignored.
  - On sel_fall:
    - If exactly ENTRIES*3 bytes were received and overflow=0 → WAIT_SWAP.
    - Otherwise → IDLE with a load_err pulse; active bank is unchanged.
  - ioctl_wr and sel_fall in the same cycle: the byte is counted first, then the end decision is made.
- WAIT_SWAP:
  - First cycle with swap_en=1 → flip active bank, set loaded, → IDLE. The flip is visible to rd_rgb on the next lookup.
  - A sel_rise here cancels the pending swap (no load_err) → LOAD; the shadow bank is overwritten.
- Only whole loads commit. The shadow bank's prior contents are don't-care, because any committed load has written every entry.
- Lookup:
  - rd_rgb <= bank[active][rd_idx] every cycle; 1-cycle latency.
  - Shadow writes never affect rd_rgb.
- ioctl_addr is not used; counters alone define byte position.
- Arithmetic: entry counter is $clog2(ENTRIES)+1 bits so that ENTRIES is detectable; channel counter is 2 bits and wraps 2→0.

Decomposition:
- Package pcw_video_pkg:
  - typedef enum {IDLE, LOAD, WAIT_SWAP} pal_state_t.
  - Function pal_entry(vec, i) for slicing DEFAULT_PAL.
  - Constant PAL_IDX_DEFAULT=8'd3.
- Sub-module pcw_palette_bank: 2×ENTRIES register file with one write port (bank, addr, data) and one registered read port (bank, addr). Reset loads DEFAULT_PAL. The FSM and counters stay in the top.

Test Plan:
- Reset with DEFAULT_PAL entry 2 = 24'h32CD32, rd_idx=2 → rd_rgb=24'h32CD32 one cycle later; busy=0, loaded=0.
- Index 3 download of 48 bytes (entry k = {k,k+16,k+32}), swap_en held 0 → busy=1 and old palette unchanged. Then raise swap_en → next cycle busy=0, loaded=1, and rd_idx=5 gives 24'h051525.
- Download of 47 bytes → load_err single pulse at the end; palette unchanged; loaded unchanged.
- Download of 50 bytes → overflow; load_err pulse; no swap even with swap_en=1.
- Index 2 download of 48 bytes → no state change; busy stays 0.
- Complete load sitting in WAIT_SWAP, then a second 48-byte load of 24'hFFFFFF entries, then swap_en → all entries read FFFFFF.
- reset_n pulsed mid-LOAD → outputs return to reset values asynchronously and defaults are restored.
- CW=6 build, byte 8'hFC → channel reads 6'h3F.
